// File: rtl/dm_store_port_if.sv
// Store-port bus between the memory stage and the data memory.
// The master side issues store requests and read addresses; the slave side
// (the memory) returns the raw read word, the byte enables and error status.
interface dm_store_port_if;
  logic        we;
  logic [1:0]  store_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  be;
  logic        align_err;
  logic        range_err;
  logic [31:0] err_addr;
  logic [31:0] store_cnt;

  modport master (
    output we, store_op, addr, wdata,
    input  rdata, be, align_err, range_err, err_addr, store_cnt
  );

  modport slave (
    input  we, store_op, addr, wdata,
    output rdata, be, align_err, range_err, err_addr, store_cnt
  );
endinterface

// File: rtl/dm_store_port.sv
// Memory-stage data memory with the store side of the byte-lane protocol.
// Stores (sw/sh/sb) become byte enables plus lane-replicated data and are
// committed on the rising clock edge; loads return the raw word with no
// latency, leaving byte/halfword extraction to writeback. Misaligned or
// out-of-range stores are dropped and recorded in sticky error flags, with
// the address of the first offender kept for software to inspect.
module dm_store_port #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  dm_store_port_if.slave bus
);

  localparam int          NUM_WORDS  = 1 << ADDR_W;
  // Span is held in 33 bits so a full 2^30-word array still compares correctly.
  localparam logic [32:0] SPAN_BYTES = 33'(NUM_WORDS) << 2;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  logic [31:0]       mem [NUM_WORDS];
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              store_req;
  logic              misaligned;
  logic              commit;
  logic              reject;
  logic [3:0]        be_int;
  logic [31:0]       lane_data;
  logic              align_err_q;
  logic              range_err_q;
  logic [31:0]       err_addr_q;
  logic [31:0]       store_cnt_q;

  // Addresses below BASE wrap to a huge offset, so a single unsigned
  // compare covers both ends of the window.
  assign off       = bus.addr - BASE;
  assign in_range  = {1'b0, off} < SPAN_BYTES;
  assign word_idx  = off[ADDR_W+1:2];
  assign store_req = bus.we && (bus.store_op != 2'b11);
  assign commit    = store_req && !misaligned && in_range;
  assign reject    = store_req && (misaligned || !in_range);

  // Decode the store size into byte enables, replicated lane data and the
  // alignment check; enables are still reported for rejected requests.
  always_comb begin
    be_int     = 4'b0000;
    lane_data  = bus.wdata;
    misaligned = 1'b0;
    case (bus.store_op)
      OP_SW: begin
        be_int     = 4'b1111;
        lane_data  = bus.wdata;
        misaligned = bus.addr[1:0] != 2'b00;
      end
      OP_SH: begin
        be_int     = bus.addr[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{bus.wdata[15:0]}};
        misaligned = bus.addr[0];
      end
      OP_SB: begin
        be_int     = 4'b0001 << bus.addr[1:0];
        lane_data  = {4{bus.wdata[7:0]}};
        misaligned = 1'b0;
      end
      default: begin
        be_int = 4'b0000;
      end
    endcase
    if (!bus.we) begin
      be_int = 4'b0000;
    end
  end

  // Word array: cleared by reset, otherwise only the enabled lanes change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_int[b]) begin
          mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
        end
      end
    end
  end

  // Committed-store counter, free-running and wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_cnt_q <= '0;
    end else if (commit) begin
      store_cnt_q <= store_cnt_q + 32'd1;
    end
  end

  // Sticky fault flags; the address is latched only for the very first fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err_q <= 1'b0;
      range_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else if (reject) begin
      if (!align_err_q && !range_err_q) begin
        err_addr_q <= bus.addr;
      end
      if (misaligned) begin
        align_err_q <= 1'b1;
      end
      if (!in_range) begin
        range_err_q <= 1'b1;
      end
    end
  end

  // Raw read with no bypass: a same-cycle store shows up one cycle later.
  always_comb begin
    bus.rdata = 32'h0;
    if (in_range) begin
      bus.rdata = mem[word_idx];
    end
  end

  assign bus.be        = be_int;
  assign bus.align_err = align_err_q;
  assign bus.range_err = range_err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.store_cnt = store_cnt_q;

endmodule

// File: tb/tb_dm_store_port.sv
// Bench for dm_store_port: a byte-addressed reference model tracks memory
// contents, counters and error flags; a compare process checks every DUT
// output at each falling edge, and directed steps pin known literal values.
module tb_dm_store_port;

  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   started = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dm_store_port_if bus ();

  dm_store_port #(
    .ADDR_W (12),
    .BASE   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model state: byte contents keyed by byte offset.
  byte unsigned mb [int unsigned];
  logic [31:0]  m_cnt   = 32'h0;
  logic         m_align = 1'b0;
  logic         m_range = 1'b0;
  logic [31:0]  m_err   = 32'h0;

  function automatic int op_size(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] op,
                                        input logic [31:0] a);
    int sz;
    int start;
    logic [3:0] r;
    r = 4'b0000;
    if (we && op != 2'b11) begin
      sz    = op_size(op);
      start = (int'(a[1:0]) / sz) * sz;
      for (int j = 0; j < sz; j++) r[start + j] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    int unsigned base;
    r = 32'h0;
    if (a < SPAN) begin
      base = a & ~32'd3;
      for (int j = 0; j < 4; j++)
        if (mb.exists(base + j)) r[8*j +: 8] = mb[base + j];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edges as the DUT, from the stable inputs.
  always @(posedge clk or posedge reset) begin
    int sz;
    int start;
    int unsigned base;
    bit mis;
    bit oor;
    if (reset) begin
      mb.delete();
      m_cnt   = 32'h0;
      m_align = 1'b0;
      m_range = 1'b0;
      m_err   = 32'h0;
    end else if (bus.we && bus.store_op != 2'b11) begin
      sz    = op_size(bus.store_op);
      start = (int'(bus.addr[1:0]) / sz) * sz;
      mis   = (int'(bus.addr[1:0]) % sz) != 0;
      oor   = !(bus.addr < SPAN);
      if (!mis && !oor) begin
        base = bus.addr & ~32'd3;
        for (int j = 0; j < sz; j++) mb[base + start + j] = bus.wdata[8*j +: 8];
        m_cnt = m_cnt + 1;
      end else begin
        if (!m_align && !m_range) m_err = bus.addr;
        if (mis) m_align = 1'b1;
        if (oor) m_range = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("be", {28'h0, bus.be}, {28'h0, exp_be(bus.we, bus.store_op, bus.addr)});
      checkOutput("rdata", bus.rdata, exp_rdata(bus.addr));
      checkOutput("align_err", {31'h0, bus.align_err}, {31'h0, m_align});
      checkOutput("range_err", {31'h0, bus.range_err}, {31'h0, m_range});
      checkOutput("err_addr", bus.err_addr, m_err);
      checkOutput("store_cnt", bus.store_cnt, m_cnt);
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.we       = we;
    bus.store_op = op;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Directed steps with literal expectations, then a randomized run.
  initial begin
    logic [31:0] a;
    bus.we       = 1'b0;
    bus.store_op = 2'b11;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    #1 reset = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Full-word store then read back.
    applyStimulus(1'b1, 2'b00, 32'h0, 32'h1122_3344);
    settle();
    checkOutput("t1_be", {28'h0, bus.be}, 32'hF);
    applyStimulus(1'b0, 2'b11, 32'h0, 32'h0);
    settle();
    checkOutput("t1_rdata", bus.rdata, 32'h1122_3344);
    checkOutput("t1_cnt", bus.store_cnt, 32'd1);

    // Byte and halfword lane merges.
    applyStimulus(1'b1, 2'b10, 32'h2, 32'h0000_00AB);
    settle();
    checkOutput("t2_sb_be", {28'h0, bus.be}, 32'h4);
    applyStimulus(1'b1, 2'b01, 32'h0, 32'h0000_BEEF);
    settle();
    checkOutput("t2_sh_be", {28'h0, bus.be}, 32'h3);
    applyStimulus(1'b0, 2'b11, 32'h0, 32'h0);
    settle();
    checkOutput("t2_rdata", bus.rdata, 32'h11AB_BEEF);
    checkOutput("t2_cnt", bus.store_cnt, 32'd3);

    // Misaligned word store is rejected; first fault address is kept.
    applyStimulus(1'b1, 2'b00, 32'h6, 32'hDEAD_BEEF);
    settle();
    checkOutput("t3_be", {28'h0, bus.be}, 32'hF);
    applyStimulus(1'b0, 2'b11, 32'h4, 32'h0);
    settle();
    checkOutput("t3_word1", bus.rdata, 32'h0);
    checkOutput("t3_align", {31'h0, bus.align_err}, 32'h1);
    checkOutput("t3_err_addr", bus.err_addr, 32'h6);
    checkOutput("t3_cnt", bus.store_cnt, 32'd3);
    applyStimulus(1'b1, 2'b01, 32'h9, 32'h1234);
    applyStimulus(1'b0, 2'b11, 32'h8, 32'h0);
    settle();
    checkOutput("t3_err_keep", bus.err_addr, 32'h6);

    // Top word is writable; one past the end is rejected and reads zero.
    applyStimulus(1'b1, 2'b00, 32'h3FFC, 32'hCAFE_F00D);
    applyStimulus(1'b1, 2'b00, 32'h4000, 32'h0000_0001);
    applyStimulus(1'b0, 2'b11, 32'h3FFC, 32'h0);
    settle();
    checkOutput("t4_top", bus.rdata, 32'hCAFE_F00D);
    checkOutput("t4_range", {31'h0, bus.range_err}, 32'h1);
    checkOutput("t4_cnt", bus.store_cnt, 32'd4);
    checkOutput("t4_err_keep", bus.err_addr, 32'h6);
    applyStimulus(1'b0, 2'b11, 32'h4000, 32'h0);
    settle();
    checkOutput("t4_oor_rdata", bus.rdata, 32'h0);

    // Same-cycle store and read, then an ignored store_op=11.
    applyStimulus(1'b1, 2'b00, 32'h10, 32'h5);
    settle();
    checkOutput("t5_old", bus.rdata, 32'h0);
    applyStimulus(1'b1, 2'b11, 32'h10, 32'h7);
    settle();
    checkOutput("t5_new", bus.rdata, 32'h5);
    checkOutput("t5_nop_be", {28'h0, bus.be}, 32'h0);
    applyStimulus(1'b0, 2'b11, 32'h10, 32'h0);
    settle();
    checkOutput("t5_nop_data", bus.rdata, 32'h5);
    checkOutput("t5_nop_cnt", bus.store_cnt, 32'd5);

    // Randomized traffic checked entirely by the compare process.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h3FF0 + 32'($urandom_range(0, 15));
        1:       a = 32'h4000 + 32'($urandom_range(0, 7));
        2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 127));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, $urandom);
    end

    // Reset asserted between edges clears everything at once.
    applyStimulus(1'b1, 2'b00, 32'h8, 32'h1234_5678);
    applyStimulus(1'b0, 2'b11, 32'h8, 32'h0);
    settle();
    checkOutput("t6_pre", bus.rdata, 32'h1234_5678);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("t6_rdata", bus.rdata, 32'h0);
    checkOutput("t6_cnt", bus.store_cnt, 32'h0);
    checkOutput("t6_align", {31'h0, bus.align_err}, 32'h0);
    checkOutput("t6_range", {31'h0, bus.range_err}, 32'h0);
    checkOutput("t6_err_addr", bus.err_addr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 2'b11, 32'h3FFC, 32'h0);
    settle();
    checkOutput("t6_top_cleared", bus.rdata, 32'h0);
    applyStimulus(1'b1, 2'b00, 32'h20, 32'h0000_A5A5);
    applyStimulus(1'b0, 2'b11, 32'h20, 32'h0);
    settle();
    checkOutput("t6_post_store", bus.rdata, 32'h0000_A5A5);
    checkOutput("t6_post_cnt", bus.store_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_store_port.md
Name: dm_store_port

Overview:
- Memory-stage data memory holding the word array, with the store (write) side of the load/store byte-lane protocol.
- Converts sw/sh/sb requests into byte enables and lane-replicated write data, commits them on the clock edge, and returns the raw 32-bit word for loads.
- Load byte/halfword selection and extension is done downstream in the writeback stage.
- Byte lane convention is little-endian: addr[1:0]=0 selects bits 7:0, addr[1:0]=3 selects bits 31:24.

Parameters:
ADDR_W, 12, word-address width; the array holds 2^ADDR_W 32-bit words.
BASE, 32'h0000_0000, byte address mapped to word 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
we  input  1  store request valid this cycle.
store_op  input  2  00=sw, 01=sh, 10=sb, 11=no store (ignored).
addr  input  32  byte address, from ALU output.
wdata  input  32  store data (rt value, already forwarded).
rdata  output  32  raw word at addr's word index (combinational).
be  output  4  byte enables for the current request (combinational).
align_err  output  1  sticky: a misaligned store was rejected.
range_err  output  1  sticky: an out-of-range store was rejected.
err_addr  output  32  byte address of the first rejected store.
store_cnt  output  32  count of committed stores.

Behaviour:
Address mapping:
- off = addr - BASE; word index = off[ADDR_W+1:2].
- The access is in range iff off < 4*2^ADDR_W, computed unsigned.

Byte enables (be), combinational:
- Forced to 0000 when we=0 or store_op=11.
- sw: 1111.
- sh: 1100 if addr[1]=1, else 0011.
- sb: 0001 shifted left by addr[1:0].

Lane data:
- sw: wdata.
- sh: {wdata[15:0], wdata[15:0]}.
- sb: wdata[7:0] replicated 4 times.
- Only lanes with be[i]=1 are modified; the other bytes of the word keep their old value.

Alignment:
- sw is misaligned if addr[1:0] != 00.
- sh is misaligned if addr[0] = 1.
- sb is never misaligned.

Commit, on rising clk when we=1, store_op != 11, aligned and in range:
- Write the enabled lanes.
- store_cnt increments by 1, wrapping from FFFF_FFFF to 0.

Reject (we=1, store_op != 11, misaligned or out of range):
- No array write and no count.
- Misaligned sets align_err; out of range sets range_err. Both set if both conditions hold.
- err_addr captures addr only if both flags were 0 before this edge. Later faults never overwrite it.

Read:
- rdata = array[word index] with no latency. If out of range, rdata = 0.
- A store and a read to the same word in one cycle: rdata shows the old word that cycle and the new word from the next cycle. No internal bypass.

Reset (asynchronous, takes effect immediately, even mid-sequence):
- Every array word = 0, store_cnt = 0, align_err = 0, range_err = 0, err_addr = 0.
- be and rdata follow combinationally, so rdata = 0.
- A store coincident with reset assertion is lost.
- After deassertion, the first store commits on the first following rising edge.

Boundaries:
- Highest word (off = 4*2^ADDR_W - 4) is writable.
- off = 4*2^ADDR_W and addresses below BASE (which wrap to a large off) raise range_err.
- Back-to-back stores every cycle are supported with no stall.

Test Plan:
1. Reset, then sw addr=0x0 wdata=0x11223344 -> be=1111. Next cycle rdata=0x11223344 and store_cnt=1.
2. Word 0 = 0x11223344; sb addr=0x2 wdata=0x000000AB -> be=0100, word 0 becomes 0x11AB3344. Then sh addr=0x0 wdata=0xBEEF -> be=0011, word 0 becomes 0x11ABBEEF. store_cnt=3.
3. sw addr=0x6 -> be=1111 (enables still reported for the request), but word 1 is unchanged. align_err=1, err_addr=0x6, store_cnt unchanged. A later sh addr=0x9 keeps err_addr=0x6.
4. ADDR_W=12: sw addr=0x3FFC wdata=0xCAFEF00D commits. sw addr=0x4000 sets range_err=1 with no write, and rdata for 0x4000 is 0.
5. Same-cycle sw addr=0x10 wdata=0x5 with the read at 0x10 -> rdata is the old value that cycle and 0x5 the next cycle. we=1 with store_op=11 -> be=0000, no write, no count.
6. After several stores, assert reset between clock edges -> all outputs and rdata go to 0 immediately, before the next edge. Reads of previously written words return 0 after deassertion.
